seq_mult_norm: RTL
==================

Name: seq_mult_norm

Overview:
Parametrised sequential shift-add multiplier with start/done handshake. It is the successor to the fixed 16-bit multiplier top.
- Adds a generic operand width and a runtime signed/unsigned mode.
- Normalises the 2*WIDTH product by leading-one detection and returns an OUT_W-bit mantissa plus shift amount, sign and zero flags.
- Feeds the fixed-point datapath, where products are later rescaled by shamt.

Parameters:
WIDTH, 16, operand width in bits (>=4)
OUT_W, 16, mantissa output width; legal range 1..2*WIDTH
SH_W, $clog2(2*WIDTH), width of shamt (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  request; sampled only in IDLE
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
A  in  WIDTH  multiplicand, sampled with start
B  in  WIDTH  multiplier, sampled with start
Y  out  OUT_W  normalised product magnitude, MSB = leading one
shamt  out  SH_W  left shift applied (leading-zero count of the 2*WIDTH product)
neg  out  1  product sign (signed mode only)
zero  out  1  product is zero
busy  out  1  high in MUL and NORM
done  out  1  one-cycle pulse when Y/shamt/neg/zero become valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, accumulator=0; Y=0, shamt=0, neg=0, zero=0, busy=0, done=0.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE: if start=1 at edge k:
  - latch magnitudes |A| and |B|; when is_signed=0 these are the raw values.
  - latch sign = is_signed & (A[W-1]^B[W-1]).
  - clear P (2*WIDTH bits) and counter; go to MUL.
- MUL: one bit of |B| per cycle, LSB first. P += |A|<<i when the bit is set. Exactly WIDTH cycles (edges k+1..k+WIDTH), then go to NORM.
- NORM: one cycle (edge k+WIDTH+1):
  - lz = leading-zero count of P.
  - Y = (P<<lz)[2W-1 -: OUT_W], truncated (no rounding); shamt=lz; neg=sign; zero=(P==0).
  - If P=0: Y=0, shamt=0, neg=0, zero=1.
  - Go to DONE.
- DONE: done=1 for exactly this one cycle, then IDLE. Y/shamt/neg/zero hold until the next NORM or reset.
- Latency: done high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after the start edge.
- start while busy or in DONE: ignored; no queuing, no restart.
- start held high continuously: a new operation begins on the first IDLE edge after DONE.
- Signed minimum (-2^(W-1)): magnitude 2^(W-1) fits in WIDTH unsigned bits; no overflow.
- Operands are captured at start; changes to A/B/is_signed mid-operation have no effect.
- Reset mid-operation: immediate abort to reset values; no done pulse; the next start behaves normally.

Decomposition:
- Package seq_mult_pkg:
  - FSM state enum (IDLE, MUL, NORM, DONE).
  - Default WIDTH/OUT_W constants.
  - Function for SH_W.
- Sub-module mult_lzc: parametrised combinational leading-zero counter over 2*WIDTH bits. Outputs count and an all-zero flag; used in NORM.

Test Plan:
- Unsigned: WIDTH=16, OUT_W=16, A=0x1000, B=0x2E00, is_signed=0. P=0x02E00000, so Y=0xB800, shamt=6, neg=0, zero=0. done exactly 18 cycles after the start edge.
- Unsigned back-to-back: A=0x0002, B=0x05C0 after the first done. P=0x00000B80, so Y=0xB800, shamt=20, zero=0.
- Signed: A=0xFFFE (-2), B=0x0003, is_signed=1. Y=0xC000, shamt=29, neg=1. Signed minimum: A=B=0x8000 gives Y=0x8000, shamt=1, neg=0.
- Zero: A=0x0000, B=0x1234. Y=0, shamt=0, zero=1, neg=0; done still at 18 cycles.
- start pulsed at cycle 5 of MUL with different operands: ignored, and the first result is unchanged. Holding start high yields continuous operations, one every 19 cycles (WIDTH+3: MUL, NORM, DONE, then an IDLE capture edge).
- rst driven low during MUL cycle 7: Y/shamt/busy/done go 0 immediately with no clock. After release, A=0x1000, B=0x2E00 gives Y=0xB800, shamt=6 normally.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the normalising sequential multiplier.
package seq_mult_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OUT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  // Width needed to express a leading-zero count over a 2*width product.
  function automatic int sh_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/mult_lzc.sv
// Combinational leading-zero counter; all_zero_o flags the all-zero input,
// whose true count does not fit in cnt_o.
module mult_lzc #(
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  d_i,
  output logic [CW-1:0] cnt_o,
  output logic          all_zero_o
);

  // Scan upward so the highest set bit is the last assignment to win.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      if (d_i[i]) cnt_o = CW'(N - 1 - i);
    end
  end

  assign all_zero_o = (d_i == '0);

endmodule

// File: rtl/seq_mult_norm.sv
// Sequential shift-add multiplier with signed/unsigned mode and a normalised
// (leading-one aligned) mantissa result. start/done handshake, one op at a time.
module seq_mult_norm
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int OUT_W = DEF_OUT_W,
  localparam int SH_W  = sh_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [OUT_W-1:0] Y,
  output logic [SH_W-1:0]  shamt,
  output logic             neg,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int PW = 2 * WIDTH;

  // Handshake: start is sampled only in IDLE; done pulses for exactly one
  // cycle when Y/shamt/neg/zero update, and those outputs hold until the next
  // result. start seen while busy or during the done cycle is dropped.

  state_t            state_q;
  logic [SH_W-1:0]   cnt_q;
  logic [PW-1:0]     p_q;
  logic [PW-1:0]     a_sh_q;
  logic [WIDTH-1:0]  b_q;
  logic              sign_q;
  logic [OUT_W-1:0]  y_q;
  logic [SH_W-1:0]   shamt_q;
  logic              neg_q;
  logic              zero_q;
  logic              busy_q;
  logic              done_q;

  logic [WIDTH-1:0]  a_mag_d;
  logic [WIDTH-1:0]  b_mag_d;
  logic [PW-1:0]     p_d;
  logic [SH_W-1:0]   lz_cnt;
  logic              p_zero;
  logic [PW-1:0]     p_norm;
  logic [OUT_W-1:0]  y_d;

  // The most negative operand negates to itself, which read unsigned is the
  // correct magnitude.
  assign a_mag_d = (is_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag_d = (is_signed && B[WIDTH-1]) ? -B : B;

  assign p_d = b_q[0] ? (p_q + a_sh_q) : p_q;

  mult_lzc #(
    .N  (PW),
    .CW (SH_W)
  ) u_lzc (
    .d_i        (p_q),
    .cnt_o      (lz_cnt),
    .all_zero_o (p_zero)
  );

  assign p_norm = p_q << lz_cnt;
  assign y_d    = p_norm[PW-1 -: OUT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_sh_q  <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      y_q     <= '0;
      shamt_q <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q  <= {{WIDTH{1'b0}}, a_mag_d};
            b_q     <= b_mag_d;
            sign_q  <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          p_q    <= p_d;
          a_sh_q <= a_sh_q << 1;
          b_q    <= b_q >> 1;
          cnt_q  <= cnt_q + SH_W'(1);
          if (cnt_q == SH_W'(WIDTH - 1)) state_q <= S_NORM;
        end
        S_NORM: begin
          y_q     <= p_zero ? '0 : y_d;
          shamt_q <= p_zero ? '0 : lz_cnt;
          neg_q   <= sign_q & ~p_zero;
          zero_q  <= p_zero;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Y         = y_q;
  assign shamt     = shamt_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
